// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and defaults for the memory responder
// Contents:
//   state_t         FSM state encoding (IDLE=0, ACCESS=1, DONE=2)
//   DEF_ADDR_WIDTH  default word-address width
//   DEF_DATA_WIDTH  default word width
//   CNT_WIDTH       wait-state counter width (WAIT_CYCLES range 0..15)
package mem_pkg;

    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int CNT_WIDTH      = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACCESS = ST_ACCESS,
        DONE   = ST_DONE
    } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bundle between the MAR/MDR datapath and memory
// Signals:
//   Address, WriteData, Read, Write   requester -> memory
//   Mdatain, Done, Busy, Err          memory -> requester
// Modports: master (requester side), slave (memory side).
interface mem_responder_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  Read;
    logic                  Write;
    logic [DATA_WIDTH-1:0] Mdatain;
    logic                  Done;
    logic                  Busy;
    logic                  Err;

    modport master (
        output Address, WriteData, Read, Write,
        input  Mdatain, Done, Busy, Err
    );

    modport slave (
        input  Address, WriteData, Read, Write,
        output Mdatain, Done, Busy, Err
    );
endinterface

// File: rtl/mem_responder_mem_array.sv
// rtl/mem_responder_mem_array.sv - single-port synchronous word RAM
module mem_array #(
    parameter int    ADDR_WIDTH = 9,
    parameter int    DATA_WIDTH = 32,
    parameter string INIT_FILE  = ""
) (
    input  logic                  Clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge Clock) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-stated memory responder with four-phase Done handshake
// Ports:
//   Clock  in       rising-edge clock
//   Clear  in       synchronous active-high reset (RAM contents kept)
//   bus    slave    Address/WriteData/Read/Write in; Mdatain/Done/Busy/Err out
// A request is latched in IDLE, waits WAIT_CYCLES cycles in ACCESS, performs the
// access, then holds Done in DONE until both Read and Write are low.
module mem_responder
    import mem_pkg::*;
#(
    parameter int    ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int    DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic            Clock,
    input  logic            Clear,
    mem_responder_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] WAIT_LOAD = CNT_WIDTH'(WAIT_CYCLES);

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    rd_q, rd_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   mdata_q, mdata_d;

    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   ram_dout;

    mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_mem (
        .Clock (Clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .din   (wdata_q),
        .dout  (ram_dout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        err_d    = 1'b0;
        mdata_d  = mdata_q;
        ram_we   = 1'b0;
        ram_addr = addr_q;

        case (state_q)
            IDLE: begin
                // Present the live address so the RAM has already read the
                // target word by the first ACCESS edge, even with zero wait states.
                ram_addr = bus.Address;
                if (bus.Read || bus.Write) begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_LOAD;
                    addr_d  = bus.Address;
                    wdata_d = bus.WriteData;
                    rd_d    = bus.Read;
                    err_d   = bus.Read && bus.Write;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = DONE;
                    if (rd_q) begin
                        mdata_d = ram_dout;
                    end else begin
                        // Clear must abort a pending write in the same edge.
                        ram_we = !Clear;
                    end
                end
            end
            DONE: begin
                if (!bus.Read && !bus.Write) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            mdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            mdata_q <= mdata_d;
        end
    end

    assign bus.Mdatain = mdata_q;
    assign bus.Done    = (state_q == DONE);
    assign bus.Busy    = (state_q != IDLE);
    assign bus.Err     = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;
    import mem_pkg::*;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int W  = 2;

    logic Clock = 1'b0;
    logic Clear;
    always #5 Clock = ~Clock;

    mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus  ();
    mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();

    mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(W), .INIT_FILE("")) dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus.slave)
    );

    mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(0), .INIT_FILE("")) dut_w0 (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus0.slave)
    );

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int err_pulses = 0;

    // Behavioural model of the main instance: one outstanding operation,
    // completion scheduled at acceptance edge + W + 1.
    bit          m_active, m_done, m_err, m_rd, m_known;
    int          m_accept;
    logic [8:0]  m_addr;
    logic [31:0] m_wdata, m_mdata;
    logic [31:0] mmem [512];
    bit          mvalid [512];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    always @(posedge Clock) begin
        edge_n++;
        if (Clear) begin
            m_active = 0; m_done = 0; m_err = 0; m_mdata = '0; m_known = 1;
        end else begin
            m_err = 0;
            if (m_done) begin
                if (!bus.Read && !bus.Write) m_done = 0;
            end else if (m_active) begin
                if (edge_n == m_accept + W + 1) begin
                    if (m_rd) begin
                        m_known = mvalid[m_addr];
                        m_mdata = mmem[m_addr];
                    end else begin
                        mmem[m_addr]   = m_wdata;
                        mvalid[m_addr] = 1;
                    end
                    m_active = 0;
                    m_done   = 1;
                end
            end else if (bus.Read || bus.Write) begin
                m_active = 1;
                m_accept = edge_n;
                m_rd     = bus.Read;
                m_err    = bus.Read && bus.Write;
                m_addr   = bus.Address;
                m_wdata  = bus.WriteData;
            end
        end
    end

    always @(negedge Clock) begin
        if (edge_n > 0) begin
            chk("busy", 32'(bus.Busy), 32'(m_active || m_done));
            chk("done", 32'(bus.Done), 32'(m_done));
            chk("err",  32'(bus.Err),  32'(m_err));
            if (m_known) chk("mdatain", bus.Mdatain, m_mdata);
            if (bus.Err) err_pulses++;
        end
    end

    // One full four-phase transaction on the main instance; lat = edges from
    // acceptance to the first edge after which Done is observed high.
    task automatic op(input logic rd, input logic wr, input logic [8:0] a,
                      input logic [31:0] d, input int hold, input bit midchg,
                      output int lat);
        int start, n;
        @(posedge Clock); #2;
        bus.Read = rd; bus.Write = wr; bus.Address = a; bus.WriteData = d;
        start = edge_n + 1;
        if (midchg) begin
            @(posedge Clock); #2;
            bus.Address   = a + 9'd1;
            bus.WriteData = 32'h1;
        end
        n = 0;
        @(negedge Clock);
        while (!bus.Done && n < 50) begin @(negedge Clock); n++; end
        if (!bus.Done) begin
            errors++; checks++;
            $display("FAIL done_timeout: got 0 expected 1");
        end
        lat = edge_n - start;
        repeat (hold) @(negedge Clock);
        @(posedge Clock); #2;
        bus.Read = 0; bus.Write = 0;
        n = 0;
        @(negedge Clock);
        while (bus.Busy && n < 50) begin @(negedge Clock); n++; end
        if (bus.Busy) begin
            errors++; checks++;
            $display("FAIL idle_timeout: got 1 expected 0");
        end
    endtask

    task automatic op0(input logic rd, input logic wr, input logic [8:0] a,
                       input logic [31:0] d, output int lat);
        int start, n;
        @(posedge Clock); #2;
        bus0.Read = rd; bus0.Write = wr; bus0.Address = a; bus0.WriteData = d;
        start = edge_n + 1;
        n = 0;
        @(negedge Clock);
        while (!bus0.Done && n < 50) begin @(negedge Clock); n++; end
        lat = edge_n - start;
        @(posedge Clock); #2;
        bus0.Read = 0; bus0.Write = 0;
        @(negedge Clock); @(negedge Clock);
        chk("w0_release", 32'({bus0.Done, bus0.Busy}), 32'd0);
    endtask

    logic [8:0]  pool [8];
    logic [31:0] pool_init [8];

    initial begin
        int lat, e0;
        pool[0] = 9'h010; pool_init[0] = 32'h0000_0010;
        pool[1] = 9'h011; pool_init[1] = 32'h1111_1111;
        pool[2] = 9'h020; pool_init[2] = 32'h1234_5678;
        pool[3] = 9'h030; pool_init[3] = 32'h0BAD_F00D;
        pool[4] = 9'h1FF; pool_init[4] = 32'h1FF1_FF00;
        pool[5] = 9'h000; pool_init[5] = 32'hA5A5_0000;
        pool[6] = 9'h0AA; pool_init[6] = 32'h0000_00AA;
        pool[7] = 9'h155; pool_init[7] = 32'h5555_0155;
        for (int i = 0; i < 512; i++) mvalid[i] = 0;

        bus.Read = 0;  bus.Write = 0;  bus.Address = '0;  bus.WriteData = '0;
        bus0.Read = 0; bus0.Write = 0; bus0.Address = '0; bus0.WriteData = '0;
        Clear = 1;
        repeat (2) @(posedge Clock);
        #2; Clear = 0;
        @(negedge Clock);
        chk("rst_mdatain", bus.Mdatain, 32'h0);
        chk("rst_done",    32'(bus.Done), 32'h0);
        chk("rst_busy",    32'(bus.Busy), 32'h0);
        chk("rst_err",     32'(bus.Err),  32'h0);
        chk("rst_w0",      32'({bus0.Done, bus0.Busy, bus0.Err}), 32'h0);

        for (int i = 0; i < 8; i++) op(0, 1, pool[i], pool_init[i], 0, 0, lat);

        // Write then read with latency pinned to W+1 = 3 edges.
        op(0, 1, 9'h010, 32'hDEAD_BEEF, 0, 0, lat);
        chk("wr_latency", 32'(lat), 32'd3);
        op(1, 0, 9'h010, 32'h0, 0, 0, lat);
        chk("rd_latency", 32'(lat), 32'd3);
        chk("rd_data_010", bus.Mdatain, 32'hDEAD_BEEF);

        // Inputs changed mid-access must not affect the latched request.
        op(0, 1, 9'h010, 32'hCAFE_F00D, 0, 1, lat);
        op(1, 0, 9'h010, 32'h0, 0, 0, lat);
        chk("latched_010", bus.Mdatain, 32'hCAFE_F00D);
        op(1, 0, 9'h011, 32'h0, 0, 0, lat);
        chk("untouched_011", bus.Mdatain, 32'h1111_1111);

        // Read and Write together: read wins, one Err pulse, no write.
        e0 = err_pulses;
        op(1, 1, 9'h020, 32'hAAAA_5555, 0, 0, lat);
        chk("err_pulses", 32'(err_pulses - e0), 32'd1);
        chk("both_rd_data", bus.Mdatain, 32'h1234_5678);
        op(1, 0, 9'h020, 32'h0, 0, 0, lat);
        chk("no_write_020", bus.Mdatain, 32'h1234_5678);

        // Clear one edge after acceptance aborts the write.
        @(posedge Clock); #2;
        bus.Write = 1; bus.Address = 9'h030; bus.WriteData = 32'hFFFF_FFFF;
        @(posedge Clock); #2;
        Clear = 1;
        @(posedge Clock); #2;
        Clear = 0; bus.Write = 0;
        @(negedge Clock);
        chk("clear_busy", 32'(bus.Busy), 32'd0);
        chk("clear_mdatain", bus.Mdatain, 32'h0);
        repeat (4) @(negedge Clock);
        op(1, 0, 9'h030, 32'h0, 0, 0, lat);
        chk("aborted_030", bus.Mdatain, 32'h0BAD_F00D);

        // Handshake hold at the top address.
        op(1, 0, 9'h1FF, 32'h0, 5, 0, lat);
        chk("wrap_1ff", bus.Mdatain, 32'h1FF1_FF00);

        // Zero wait-state instance: Done after E0+1.
        op0(0, 1, 9'h1FF, 32'h55AA_33CC, lat);
        chk("w0_wr_latency", 32'(lat), 32'd1);
        op0(1, 0, 9'h1FF, 32'h0, lat);
        chk("w0_rd_latency", 32'(lat), 32'd1);
        chk("w0_rd_data", bus0.Mdatain, 32'h55AA_33CC);

        // Randomized traffic over the initialized address pool.
        for (int i = 0; i < 40; i++) begin
            int k, kind;
            k    = $urandom_range(0, 7);
            kind = $urandom_range(0, 4);
            op(kind != 0 && kind != 1, kind <= 1 || kind == 4, pool[k], $urandom,
               $urandom_range(0, 3), ($urandom_range(0, 3) == 0) && k != 7, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
